hex_display_sequencer: RTL and testbench



---
 rtl/hex_display_sequencer_pkg.sv | 55 +++++
 rtl/hex_display_sequencer_if.sv | 22 ++
 rtl/hex_display_sequencer_key_debounce.sv | 48 ++++
 rtl/hex_display_sequencer.sv | 139 +++++++++++++
 tb/tb_hex_display_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_display_sequencer_pkg.sv
// Shared types and helpers for the hex display sequencer.
package hex_disp_pkg;

    // Mode encodings kept as plain constants so legacy code can still compare against them
    localparam logic [1:0] MODE_ENC_SW     = 2'd0;
    localparam logic [1:0] MODE_ENC_BDAY   = 2'd1;
    localparam logic [1:0] MODE_ENC_SCROLL = 2'd2;

    typedef enum logic [1:0] {
        SHOW_SW   = MODE_ENC_SW,
        SHOW_BDAY = MODE_ENC_BDAY,
        SCROLL    = MODE_ENC_SCROLL
    } mode_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low seven-segment code, bit0..6 = a..g, dp (bit7) always off
    function automatic logic [7:0] seg7(input logic [3:0] nibble);
        case (nibble)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    function automatic mode_t nextMode(input mode_t m);
        case (m)
            SHOW_SW:   return SHOW_BDAY;
            SHOW_BDAY: return SCROLL;
            default:   return SHOW_SW;
        endcase
    endfunction

    function automatic logic [2:0] modeOneHot(input mode_t m);
        case (m)
            SHOW_SW:   return 3'b100;
            SHOW_BDAY: return 3'b010;
            default:   return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/hex_display_sequencer_if.sv
// Board I/O bundle: slide switches and keys in, LEDs and six digits out.
interface hex_display_sequencer_if;
    logic [9:0] switch;
    logic [1:0] key;
    logic [9:0] leds;
    logic [7:0] hex0;
    logic [7:0] hex1;
    logic [7:0] hex2;
    logic [7:0] hex3;
    logic [7:0] hex4;
    logic [7:0] hex5;

    modport master (
        output switch, key,
        input  leds, hex0, hex1, hex2, hex3, hex4, hex5
    );

    modport slave (
        input  switch, key,
        output leds, hex0, hex1, hex2, hex3, hex4, hex5
    );
endinterface

// File: rtl/hex_display_sequencer_key_debounce.sv
// One push key: 2-FF synchronizer, level debounce, one-cycle press pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic keyRaw,
    output logic pressPulse
);
    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          keyMeta;
    logic          keySync;
    logic          keyLevel;
    logic [CW-1:0] stableCnt;

    // Bring the raw key into the clock domain; idle level is released (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyMeta <= 1'b1;
            keySync <= 1'b1;
        end else begin
            keyMeta <= keyRaw;
            keySync <= keyMeta;
        end
    end

    // Accept a new level after DEBOUNCE_CYC consecutive differing cycles; pulse on press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stableCnt  <= '0;
            keyLevel   <= 1'b1;
            pressPulse <= 1'b0;
        end else begin
            pressPulse <= 1'b0;
            if (keySync == keyLevel) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                stableCnt  <= '0;
                keyLevel   <= keySync;
                pressPulse <= ~keySync;
            end else begin
                stableCnt <= stableCnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/hex_display_sequencer.sv
// Key-driven display sequencer: live switches, stored date, or scrolling date.
module hex_display_sequencer
    import hex_disp_pkg::*;
#(
    parameter logic [23:0] BDAY         = 24'h031402,
    parameter int unsigned TICK_DIV     = 25000000,
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hex_display_sequencer_if.slave io
);
    localparam int unsigned   TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [9:0]      swMeta;
    logic [9:0]      swSync;
    logic            press0;
    logic            press1;
    mode_t           mode;
    logic            paused;
    logic            blank;
    logic [2:0]      pos;
    logic [TW-1:0]   tickCnt;
    logic [5:0][7:0] digits;
    logic [9:0]      ledsNext;
    logic [5:0][7:0] hexReg;
    logic [9:0]      ledsReg;

    // Synchronize the slide switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swMeta <= '0;
            swSync <= '0;
        end else begin
            swMeta <= io.switch;
            swSync <= swMeta;
        end
    end

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) keyDeb0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .keyRaw     (io.key[0]),
        .pressPulse (press0)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) keyDeb1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .keyRaw     (io.key[1]),
        .pressPulse (press1)
    );

    // Mode sequencing, pause/blank toggles and the scroll tick; key[1] wins over key[0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode    <= SHOW_SW;
            paused  <= 1'b0;
            blank   <= 1'b0;
            pos     <= '0;
            tickCnt <= '0;
        end else if (press1) begin
            mode    <= nextMode(mode);
            paused  <= 1'b0;
            blank   <= 1'b0;
            pos     <= '0;
            tickCnt <= '0;
        end else begin
            if (press0) begin
                if (mode == SCROLL) begin
                    paused <= ~paused;
                end else begin
                    blank <= ~blank;
                end
            end
            if (mode == SCROLL && !paused) begin
                if (tickCnt == TICK_LAST) begin
                    tickCnt <= '0;
                    pos     <= (pos == 3'd5) ? 3'd0 : pos + 3'd1;
                end else begin
                    tickCnt <= tickCnt + TW'(1);
                end
            end
        end
    end

    // Digit and LED contents for the current mode
    always_comb begin
        int unsigned idx;
        digits = {6{SEG_BLANK}};
        idx    = 0;
        case (mode)
            SHOW_SW: begin
                digits[0] = seg7(swSync[3:0]);
                digits[1] = seg7(swSync[7:4]);
                digits[2] = seg7({2'b00, swSync[9:8]});
            end
            SHOW_BDAY: begin
                for (int unsigned n = 0; n < 6; n++) begin
                    digits[n] = seg7(4'(BDAY >> (4 * n)));
                end
            end
            default: begin
                // Digit n shows nibble (n - pos) mod 6, so the date moves left as pos grows
                for (int unsigned n = 0; n < 6; n++) begin
                    idx = n + 32'd6 - 32'(pos);
                    if (idx >= 32'd6) begin
                        idx = idx - 32'd6;
                    end
                    digits[n] = seg7(4'(BDAY >> (4 * idx)));
                end
            end
        endcase
        if (blank) begin
            digits = {6{SEG_BLANK}};
        end
        ledsNext = {modeOneHot(mode), paused, swSync[5:0]};
    end

    // Register all board outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hexReg  <= {6{SEG_BLANK}};
            ledsReg <= '0;
        end else begin
            hexReg  <= digits;
            ledsReg <= ledsNext;
        end
    end

    assign io.hex0 = hexReg[0];
    assign io.hex1 = hexReg[1];
    assign io.hex2 = hexReg[2];
    assign io.hex3 = hexReg[3];
    assign io.hex4 = hexReg[4];
    assign io.hex5 = hexReg[5];
    assign io.leds = ledsReg;
endmodule

// File: tb/tb_hex_display_sequencer.sv
// Self-checking bench for hex_display_sequencer with a cycle-level behavioural model.
module tb_hex_display_sequencer;
    localparam int          TICK    = 4;
    localparam int          DEB     = 3;
    localparam logic [23:0] BDAY_TB = 24'h031402;
    localparam logic [7:0]  SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic clk;
    logic rst_n;
    hex_display_sequencer_if bus();

    hex_display_sequencer #(.BDAY(BDAY_TB), .TICK_DIV(TICK), .DEBOUNCE_CYC(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [57:0] obs;
    logic [57:0] exp;

    // Key events keyed by the clock edge on which the sequencer acts on them
    bit [1:0] evAt [int];

    // Model state (m*) and what the registered outputs show after this edge (vis*)
    int         cyc;
    logic [9:0] h1, h2, visSw;
    int         mMode, visMode;
    bit         mPaused, mBlank, visPaused, visBlank, visValid;
    int         mRun, visRun;

    function automatic bit evHas(input int n, input int b);
        if (!evAt.exists(n)) return 1'b0;
        return evAt[n][b];
    endfunction

    // Scroll position is the number of whole tick periods of unpaused scrolling, mod 6
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; h1 <= '0; h2 <= '0;
            mMode <= 0; mPaused <= 1'b0; mBlank <= 1'b0; mRun <= 0;
            visValid <= 1'b0; visMode <= 0; visPaused <= 1'b0; visBlank <= 1'b0;
            visRun <= 0; visSw <= '0;
        end else begin
            cyc <= cyc + 1;
            h1 <= bus.switch;
            h2 <= h1;
            visValid <= 1'b1; visMode <= mMode; visPaused <= mPaused;
            visBlank <= mBlank; visRun <= mRun; visSw <= h2;
            if (evHas(cyc + 1, 1)) begin
                mMode <= (mMode + 1) % 3; mPaused <= 1'b0; mBlank <= 1'b0; mRun <= 0;
            end else begin
                if (evHas(cyc + 1, 0)) begin
                    if (mMode == 2) mPaused <= !mPaused;
                    else            mBlank  <= !mBlank;
                end
                if (mMode == 2 && !mPaused) mRun <= mRun + 1;
            end
        end
    end

    function automatic logic [57:0] expectOut();
        logic [7:0]  d [6];
        logic [23:0] b;
        logic [9:0]  l;
        int          p;
        b = BDAY_TB;
        if (!visValid) return {10'h000, {6{8'hFF}}};
        for (int n = 0; n < 6; n++) d[n] = 8'hFF;
        p = (visRun / TICK) % 6;
        case (visMode)
            0: begin
                d[0] = SEG_TAB[visSw[3:0]];
                d[1] = SEG_TAB[visSw[7:4]];
                d[2] = SEG_TAB[{2'b00, visSw[9:8]}];
            end
            1: for (int n = 0; n < 6; n++) d[n] = SEG_TAB[b[4*n +: 4]];
            default: for (int n = 0; n < 6; n++) d[n] = SEG_TAB[b[4*((n + 6 - p) % 6) +: 4]];
        endcase
        if (visBlank) for (int n = 0; n < 6; n++) d[n] = 8'hFF;
        l = {visMode == 0, visMode == 1, visMode == 2, visPaused, visSw[5:0]};
        return {l, d[5], d[4], d[3], d[2], d[1], d[0]};
    endfunction

    // Clean press: low for len cycles; only len >= DEB yields an event, acted on DEB+3 edges later
    task automatic pressKeys(input logic [1:0] mask, input int len);
        @(negedge clk);
        if (len >= DEB) begin
            if (evAt.exists(cyc + 3 + DEB)) evAt[cyc + 3 + DEB] = evAt[cyc + 3 + DEB] | mask;
            else                            evAt[cyc + 3 + DEB] = mask;
        end
        bus.key = ~mask;
        repeat (len) @(negedge clk);
        bus.key = 2'b11;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key = 2'b11;
        bus.switch = 10'($urandom_range(0, 1023));
        repeat (3) @(negedge clk);
        obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
        checks++;
        if (obs !== {10'h000, {6{8'hFF}}}) begin
            errors++; $display("FAIL reset_hold got %h expected %h", obs, {10'h000, {6{8'hFF}}});
        end
        bus.switch = 10'h3A5;
        rst_n = 1'b1;
        #1;
        obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
        checks++;
        if (obs !== {10'h000, {6{8'hFF}}}) begin
            errors++; $display("FAIL reset_release got %h expected %h", obs, {10'h000, {6{8'hFF}}});
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL reset_sw cyc=%0d got %h expected %h", cyc, obs, exp); end
            if (i == 3) begin
                checks++;
                if ({bus.leds[9:7], bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0} !==
                    {3'b100, 8'hFF, 8'hFF, 8'hFF, 8'hB0, 8'h88, 8'h92}) begin
                    errors++; $display("FAIL sw_3A5 got %h %h expected 100 ffffffb08892", bus.leds[9:7],
                        {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0});
                end
            end
        end
    endtask

    task automatic test_debounce();
        pressKeys(2'b10, 2);
        repeat (12) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL glitch cyc=%0d got %h expected %h", cyc, obs, exp); end
        end
        pressKeys(2'b10, 6);
        repeat (12) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL press_bday cyc=%0d got %h expected %h", cyc, obs, exp); end
        end
        checks++;
        if ({bus.leds[9:7], bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0} !==
            {3'b010, 8'hC0, 8'hB0, 8'hF9, 8'h99, 8'hC0, 8'hA4}) begin
            errors++; $display("FAIL bday_digits got %h %h expected 010 c0b0f999c0a4", bus.leds[9:7],
                {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0});
        end
    endtask

    task automatic test_scroll();
        pressKeys(2'b10, 4);
        repeat (40) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL scroll cyc=%0d got %h expected %h", cyc, obs, exp); end
            bus.switch = 10'($urandom_range(0, 1023));
        end
    endtask

    task automatic test_pause();
        pressKeys(2'b01, 3 + int'($urandom_range(0, 3)));
        repeat (26) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL pause cyc=%0d got %h expected %h", cyc, obs, exp); end
        end
        pressKeys(2'b01, 4);
        repeat (20) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL resume cyc=%0d got %h expected %h", cyc, obs, exp); end
        end
    endtask

    task automatic test_both_keys();
        pressKeys(2'b11, 5);
        repeat (15) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL both_keys cyc=%0d got %h expected %h", cyc, obs, exp); end
            bus.switch = 10'($urandom_range(0, 1023));
        end
    endtask

    task automatic test_blank();
        pressKeys(2'b01, 4);
        repeat (15) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL blank cyc=%0d got %h expected %h", cyc, obs, exp); end
            bus.switch = 10'($urandom_range(0, 1023));
        end
        pressKeys(2'b10, 4);
        repeat (15) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL unblank cyc=%0d got %h expected %h", cyc, obs, exp); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            pressKeys(2'($urandom_range(1, 3)), int'($urandom_range(1, 6)));
            repeat (12) begin
                @(negedge clk);
                obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
                exp = expectOut();
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL random cyc=%0d got %h expected %h", cyc, obs, exp); end
                bus.switch = 10'($urandom_range(0, 1023));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3 && mMode != 2; i++) begin
            pressKeys(2'b10, 4);
            repeat (10) @(negedge clk);
        end
        repeat (int'($urandom_range(3, 9))) @(negedge clk);
        #2;
        evAt.delete();
        rst_n = 1'b0;
        #1;
        obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
        checks++;
        if (obs !== {10'h000, {6{8'hFF}}}) begin
            errors++; $display("FAIL reset_mid got %h expected %h", obs, {10'h000, {6{8'hFF}}});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            obs = {bus.leds, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            exp = expectOut();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL after_reset cyc=%0d got %h expected %h", cyc, obs, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_scroll();
        test_pause();
        test_both_keys();
        test_blank();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
